seq_approx_recursive_mult: RTL and testbench

- Parametrised, multi-cycle successor to the fixed 16x16 four-quadrant recursive multiplier.
- Reuses one exact KxK sub-multiplier across all (N/K)^2 operand-chunk pairs, one pair per cycle, into a 2N-bit accumulator.
- Runtime approximation level skips low-significance chunk pairs, trading accuracy for fewer active cycles (lower energy).
- Sits between operand source and consumer with valid/ready handshakes on both sides.

---
 rtl/seq_approx_recursive_mult.sv | 199 +++++++++++++++++++
 tb/tb_seq_approx_recursive_mult.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_approx_recursive_mult.sv
// Sequential approximate multiplier: one exact KxK sub-multiplier swept over the
// operand chunk pairs (i,j) with i+j >= approx_lvl, accumulated into a 2N-bit sum.
module seq_approx_recursive_mult #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic [N-1:0]                                         a,
    input  logic [N-1:0]                                         b,
    input  logic [$clog2(2*(N/K))-1:0]                           approx_lvl,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [2*N-1:0]                                       y,
    output logic [$clog2(2*(N/K))+$clog2(N/K):0]                 y_cycles
);

    localparam int M  = N / K;
    localparam int IW = $clog2(M);
    localparam int LW = $clog2(2 * M);
    localparam int CW = LW + IW + 1;
    localparam int W  = 2 * N;

    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_s;
    logic [N-1:0]    a_r;
    logic [N-1:0]    b_r;
    logic [LW-1:0]   lvl_r;
    logic [W-1:0]    acc_r;
    logic [IW-1:0]   i_r;
    logic [IW-1:0]   j_r;
    logic [CW-1:0]   cnt_r;
    logic            empty_r;

    logic            accept_s;
    logic            last_s;
    logic            row_end_s;
    logic [K-1:0]    a_chunk_s;
    logic [K-1:0]    b_chunk_s;
    logic [2*K-1:0]  prod_s;
    logic [W-1:0]    term_s;
    logic [W-1:0]    sum_s;
    logic [IW-1:0]   first_i_s;
    logic [IW-1:0]   first_j_s;
    logic [IW-1:0]   next_row_j_s;
    logic            empty_s;

    // First column of a row: max(0, lvl - row); callers guarantee it is <= M-1.
    function automatic logic [IW-1:0] row_start(input logic [LW-1:0] lvl, input logic [IW:0] row);
        logic [LW:0] lvl_w;
        logic [LW:0] row_w;
        logic [LW:0] diff;
        lvl_w = {1'b0, lvl};
        row_w = (LW+1)'(row);
        if (lvl_w > row_w) begin
            diff = lvl_w - row_w;
        end else begin
            diff = {(LW+1){1'b0}};
        end
        return diff[IW-1:0];
    endfunction

    // First row that has any pair with i+j >= lvl: max(0, lvl - (M-1)).
    function automatic logic [IW-1:0] first_row(input logic [LW-1:0] lvl);
        logic [LW:0] lvl_w;
        logic [LW:0] diff;
        lvl_w = {1'b0, lvl};
        if (lvl_w > (LW+1)'(M - 1)) begin
            diff = lvl_w - (LW+1)'(M - 1);
        end else begin
            diff = {(LW+1){1'b0}};
        end
        return diff[IW-1:0];
    endfunction

    // Partial product, pair walk bookkeeping and start point of a new job.
    always_comb begin
        accept_s     = in_valid & in_ready;
        last_s       = (i_r == LAST_IDX) && (j_r == LAST_IDX);
        row_end_s    = (j_r == LAST_IDX);
        a_chunk_s    = a_r[K*i_r +: K];
        b_chunk_s    = b_r[K*j_r +: K];
        prod_s       = {{K{1'b0}}, a_chunk_s} * {{K{1'b0}}, b_chunk_s};
        term_s       = {{(W-2*K){1'b0}}, prod_s} << (K * ({1'b0, i_r} + {1'b0, j_r}));
        sum_s        = acc_r + term_s;
        next_row_j_s = row_start(lvl_r, {1'b0, i_r} + (IW+1)'(1));
        first_i_s    = first_row(approx_lvl);
        first_j_s    = row_start(approx_lvl, {1'b0, first_i_s});
        empty_s      = ({1'b0, approx_lvl} > (LW+1)'(2 * M - 2));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; an empty job still spends one BUSY cycle so the result
    // handshake looks the same as for a single-pair job.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_s = BUSY;
                end else begin
                    next_s = IDLE;
                end
            end
            BUSY: begin
                if (empty_r || last_s) begin
                    next_s = DONE;
                end else begin
                    next_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_s = IDLE;
                end else begin
                    next_s = DONE;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // Operand capture, accumulation and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= {N{1'b0}};
            b_r       <= {N{1'b0}};
            lvl_r     <= {LW{1'b0}};
            acc_r     <= {W{1'b0}};
            i_r       <= {IW{1'b0}};
            j_r       <= {IW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            empty_r   <= 1'b0;
            y         <= {W{1'b0}};
            y_cycles  <= {CW{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (next_s == IDLE);
            out_valid <= (next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= a;
                        b_r     <= b;
                        lvl_r   <= approx_lvl;
                        acc_r   <= {W{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        i_r     <= first_i_s;
                        j_r     <= first_j_s;
                        empty_r <= empty_s;
                    end
                end
                BUSY: begin
                    if (empty_r) begin
                        y        <= {W{1'b0}};
                        y_cycles <= {CW{1'b0}};
                    end else begin
                        acc_r <= sum_s;
                        cnt_r <= cnt_r + CNT_ONE;
                        if (last_s) begin
                            y        <= sum_s;
                            y_cycles <= cnt_r + CNT_ONE;
                        end else if (row_end_s) begin
                            i_r <= i_r + IW'(1);
                            j_r <= next_row_j_s;
                        end else begin
                            j_r <= j_r + IW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_approx_recursive_mult.sv
// Directed self-checking bench for seq_approx_recursive_mult (N=16, K=4).
module tb_seq_approx_recursive_mult;

    localparam int N  = 16;
    localparam int K  = 4;
    localparam int LW = 3;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [LW-1:0] approx_lvl;
    logic          out_valid;
    logic          out_ready;
    logic [2*N-1:0] y;
    logic [CW-1:0] y_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_approx_recursive_mult #(.N(N), .K(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .approx_lvl (approx_lvl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .y_cycles   (y_cycles)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_y(input logic [15:0] fa, input logic [15:0] fb, input int lvl);
        logic [31:0] s;
        logic [31:0] pa;
        logic [31:0] pb;
        s = 32'd0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i + j >= lvl) begin
                    pa = 32'(fa[4*i +: 4]);
                    pb = 32'(fb[4*j +: 4]);
                    s  = s + ((pa * pb) << (4 * (i + j)));
                end
            end
        end
        return s;
    endfunction

    // Accept one operand set, scramble inputs afterwards, and measure edges to out_valid.
    task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic [LW-1:0] tl, input int exp_edges,
                         output logic [2*N-1:0] ry, output logic [CW-1:0] rc);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a = ta; b = tb; approx_lvl = tl; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        a          = N'($urandom);
        b          = N'($urandom);
        approx_lvl = LW'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_latency"}, 64'(n), 64'(exp_edges));
        ry = y;
        rc = y_cycles;
    endtask

    // With out_ready high, the block must be back in IDLE one edge later.
    task automatic handoff(input string tag);
        @(posedge clk); #1;
        check_eq({tag, "_idle_in_ready"}, 64'(in_ready), 64'd1);
        check_eq({tag, "_idle_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2*N-1:0] ry;
        logic [CW-1:0]  rc;
        int             exp_c [8];
        logic [15:0]    sa;
        logic [15:0]    sb;

        exp_c = '{16, 15, 13, 10, 6, 3, 1, 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 16'd0; b = 16'd0; approx_lvl = 3'd0;
        @(posedge clk); #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_y", 64'(y), 64'd0);
        check_eq("rst_y_cycles", 64'(y_cycles), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op("exact", 16'h1234, 16'h5678, 3'd0, 16, ry, rc);
        check_eq("exact_y", 64'(ry), 64'h06260060);
        check_eq("exact_cycles", 64'(rc), 64'd16);
        handoff("exact");

        do_op("max", 16'hFFFF, 16'hFFFF, 3'd0, 16, ry, rc);
        check_eq("max_y", 64'(ry), 64'hFFFE0001);
        check_eq("max_cycles", 64'(rc), 64'd16);
        handoff("max");

        do_op("lvl6", 16'hFFFF, 16'hFFFF, 3'd6, 1, ry, rc);
        check_eq("lvl6_y", 64'(ry), 64'hE1000000);
        check_eq("lvl6_cycles", 64'(rc), 64'd1);
        handoff("lvl6");

        do_op("lvl1", 16'h000F, 16'h000F, 3'd1, 15, ry, rc);
        check_eq("lvl1_y", 64'(ry), 64'd0);
        check_eq("lvl1_cycles", 64'(rc), 64'd15);
        handoff("lvl1");

        do_op("lvl7", 16'hABCD, 16'h1234, 3'd7, 1, ry, rc);
        check_eq("lvl7_y", 64'(ry), 64'd0);
        check_eq("lvl7_cycles", 64'(rc), 64'd0);
        handoff("lvl7");

        for (int l = 0; l < 8; l++) begin
            sa = 16'(($urandom % 16'hFFFF) + 1);
            sb = 16'(($urandom % 16'hFFFF) + 1);
            do_op("sweep", sa, sb, 3'(l), (exp_c[l] > 0) ? exp_c[l] : 1, ry, rc);
            check_eq("sweep_y", 64'(ry), 64'(ref_y(sa, sb, l)));
            check_eq("sweep_cycles", 64'(rc), 64'(exp_c[l]));
            if (l == 0) begin
                check_eq("sweep_exact_product", 64'(ry), 64'(32'(sa) * 32'(sb)));
            end
            handoff("sweep");
        end

        out_ready = 1'b0;
        do_op("bp", 16'h00FF, 16'h0101, 3'd0, 16, ry, rc);
        check_eq("bp_y", 64'(ry), 64'h0000FFFF);
        for (int k = 0; k < 5; k++) begin
            in_valid   = k[0];
            a          = N'($urandom);
            b          = N'($urandom);
            approx_lvl = 3'd0;
            @(posedge clk); #1;
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_eq("bp_y_hold", 64'(y), 64'h0000FFFF);
            check_eq("bp_cycles_hold", 64'(y_cycles), 64'd16);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release_out_valid", 64'(out_valid), 64'd0);
        check_eq("bp_release_in_ready", 64'(in_ready), 64'd1);
        check_eq("bp_idle_y_retained", 64'(y), 64'h0000FFFF);
        do_op("bp_next", 16'h0002, 16'h0007, 3'd0, 16, ry, rc);
        check_eq("bp_next_y", 64'(ry), 64'd14);
        handoff("bp_next");

        a = 16'h1234; b = 16'h5678; approx_lvl = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check_eq("busy_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_y", 64'(y), 64'd0);
        check_eq("midrst_y_cycles", 64'(y_cycles), 64'd0);
        do_op("after_rst", 16'h0003, 16'h0005, 3'd0, 16, ry, rc);
        check_eq("after_rst_y", 64'(ry), 64'd15);
        check_eq("after_rst_cycles", 64'(rc), 64'd16);
        handoff("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
